decode_queue: RTL
=================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter PW, default 96: decoded micro-op payload width in bits.
REQ-002 Parameter NUM_RS, default 4: number of reservation-station classes, at least 2.
REQ-003 Parameter DEPTH, default 4: queue entries, a power of 2 and at least 2.
REQ-004 Derived widths SHALL be SW = $clog2(NUM_RS), AW = $clog2(DEPTH) and CW = AW+1.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 globalReset  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  ROB commit of a mispredicted control-flow instruction; synchronous clear of the queue.
REQ-008 decValid  in  1  decode stage presents a micro-op.
REQ-009 decPayload  in  PW  decoded micro-op (operands, immediate, control, ROB tags).
REQ-010 decStation  in  SW  target reservation-station class.
REQ-011 decReady  out  1  queue can accept a micro-op this cycle.
REQ-012 freeze  out  1  equals !decReady; stalls fetch/decode.
REQ-013 rsFull  in  NUM_RS  per-class full flag from the reservation stations.
REQ-014 robFull  in  1  ROB has no free entry.
REQ-015 dispValid  out  1  head entry is valid.
REQ-016 dispPayload  out  PW  head payload.
REQ-017 dispStation  out  SW  head station class.
REQ-018 dispFire  out  1  head is dispatched this cycle; used as the ROB allocation and station request strobe.
REQ-019 stationReq  out  NUM_RS  one-hot of dispStation, qualified by dispFire.
REQ-020 count  out  CW  current occupancy.

Function
REQ-021 Storage SHALL be a circular buffer with DEPTH entries, each holding {payload, station}, plus an AW-bit head pointer, an AW-bit tail pointer and a CW-bit count.
REQ-022 decReady SHALL be 1 when count < DEPTH; enqueue when full is not permitted, including when a dispatch occurs in the same cycle.
REQ-023 Enqueue (enq = decValid & decReady & !flush) SHALL write the tail entry and advance tail by 1 modulo DEPTH.
REQ-024 dispValid SHALL be 1 when count != 0; dispPayload and dispStation SHALL be driven combinationally from the head entry.
REQ-025 dispFire SHALL equal dispValid & !robFull & !rsFull[dispStation] & !flush.
REQ-026 On dispFire, head SHALL advance by 1 modulo DEPTH.
REQ-027 count SHALL increment on enqueue only, decrement on dispFire only, and stay unchanged when both occur.
REQ-028 Minimum latency SHALL be 1 cycle: an entry enqueued at edge N is first dispatchable in cycle N+1; there is no bypass path.
REQ-029 Head-of-line blocking SHALL apply: the head dispatches strictly in order, and a full target class stalls all younger entries.
REQ-030 dispStation values of NUM_RS or above SHALL be treated as rsFull = 0 (an always-available class).
REQ-031 flush SHALL take priority over every other event: at the next edge head = tail = 0 and count = 0, and the cycle's enqueue and dispatch are discarded.
REQ-032 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless with no loss or duplication of entries.
REQ-033 Payload RAM contents need no reset; only pointers and count are reset.

Reset
REQ-034 While globalReset is high, head = tail = 0 and count = 0 SHALL hold.
REQ-035 During reset, decReady = 1, freeze = 0, dispValid = 0, dispFire = 0 and stationReq = 0.
REQ-036 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-037 The first enqueue SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-038 Fill: 4 enqueues with rsFull = 0 and robFull = 1 -> count = 4, decReady = 0, freeze = 1; a 5th decValid is not accepted.
REQ-039 In-order drain with blocking: station sequence 0,1,0 with rsFull = 4'b0010 -> entry 0 dispatches with stationReq = 4'b0001; entry 1 stalls; after rsFull clears, entries 1 and 2 dispatch with stationReq = 4'b0010 then 4'b0001.
REQ-040 Simultaneous events: count = 2 with enqueue and dispatch in the same cycle -> count remains 2; payload order is preserved across 10 pointer wraps.
REQ-041 Flush: count = 3, and flush arrives with decValid = 1 and dispatch possible -> dispFire = 0 that cycle, then count = 0 and dispValid = 0 the next cycle.
REQ-042 Async reset: assert globalReset between clock edges while count = 2 -> count = 0 and dispValid = 0 immediately.
REQ-043 Scoreboard: 10k random decValid, rsFull, robFull and flush cycles -> dispatched payloads equal the enqueued sequence truncated at each flush, and count never exceeds 4.

Source files
------------

// File: rtl/decode_queue.sv
// In-order decode-to-dispatch queue: a circular buffer of decoded micro-ops
// that dispatches its head to a reservation-station class when ROB and class have room.
module decode_queue #(
  parameter int PW     = 96,
  parameter int NUM_RS = 4,
  parameter int DEPTH  = 4,
  localparam int SW    = $clog2(NUM_RS),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              globalReset,
  input  logic              flush,
  input  logic              decValid,
  input  logic [PW-1:0]     decPayload,
  input  logic [SW-1:0]     decStation,
  output logic              decReady,
  output logic              freeze,
  input  logic [NUM_RS-1:0] rsFull,
  input  logic              robFull,
  output logic              dispValid,
  output logic [PW-1:0]     dispPayload,
  output logic [SW-1:0]     dispStation,
  output logic              dispFire,
  output logic [NUM_RS-1:0] stationReq,
  output logic [CW-1:0]     count
);

  logic [PW-1:0] payload_mem [DEPTH];
  logic [SW-1:0] station_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          enq;
  logic          blocked;

  // Station codes with no matching class are never reported full.
  function automatic logic class_full(input logic [SW-1:0] st,
                                      input logic [NUM_RS-1:0] full);
    class_full = 1'b0;
    for (int i = 0; i < NUM_RS; i++)
      if (st == SW'(i)) class_full = full[i];
  endfunction

  function automatic logic [NUM_RS-1:0] class_onehot(input logic [SW-1:0] st);
    class_onehot = '0;
    for (int i = 0; i < NUM_RS; i++)
      if (st == SW'(i)) class_onehot[i] = 1'b1;
  endfunction

  assign decReady    = count < CW'(DEPTH);
  assign freeze      = ~decReady;
  assign enq         = decValid & decReady & ~flush;
  assign dispValid   = count != '0;
  assign dispPayload = payload_mem[head];
  assign dispStation = station_mem[head];
  assign blocked     = class_full(dispStation, rsFull);
  assign dispFire    = dispValid & ~robFull & ~blocked & ~flush;
  assign stationReq  = dispFire ? class_onehot(dispStation) : '0;

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)      tail <= tail + AW'(1);
      if (dispFire) head <= head + AW'(1);
      case ({enq, dispFire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is data-only and never reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      payload_mem[tail] <= decPayload;
      station_mem[tail] <= decStation;
    end
  end

endmodule
